// File: rtl/half_adder_pkg.sv
// Shared types and limits for the registered half adder.
// Imported by the cell and the top.
package half_adder_pkg;

  localparam int HA_MAX_WIDTH = 64;

  typedef struct packed {
    logic c;
    logic s;
  } ha_result_t;

  function automatic ha_result_t ha_add(
    input logic a,
    input logic b
  );
    ha_result_t r;
    r.c = a & b;
    r.s = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder.
// {c, s} = a + b.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  ha_result_t res;

  assign res = ha_add(a, b);
  assign s   = res.s;
  assign c   = res.c;

endmodule

// File: rtl/half_adder_sync.sv
// WIDTH-lane half adder with registered sum/carry,
// a valid flag and a registered carry OR-reduction.
module half_adder_sync
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             any_carry
);

  if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
    $error("half_adder_sync: WIDTH out of range");
  end

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (sum_w[i]),
      .c (carry_w[i])
    );
  end

  // Data regs load only on valid so X operands on idle cycles never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      c         <= '0;
      any_carry <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s         <= sum_w;
        c         <= carry_w;
        any_carry <= |carry_w;
      end
    end
  end

endmodule

// File: tb/tb_half_adder_sync.sv
// Directed bench for half_adder_sync with a 1-lane
// and an 8-lane instance sharing clock and reset.
module tb_half_adder_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, v1;
  logic       s1, c1, ov1, ac1;
  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] s8, c8;
  logic       ov8, ac8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  half_adder_sync #(.WIDTH(1)) d1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .in_valid  (v1),
    .s         (s1),
    .c         (c1),
    .out_valid (ov1),
    .any_carry (ac1)
  );

  half_adder_sync #(.WIDTH(8)) d8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .in_valid  (v8),
    .s         (s8),
    .c         (c8),
    .out_valid (ov8),
    .any_carry (ac8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'b1;
      tick();
      n_checks++;
      if ({s1, c1, ov1, ac1} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_w1 cyc%0d got s=%b c=%b ov=%b ac=%b want all 0",
                 i, s1, c1, ov1, ac1);
      end
      n_checks++;
      if ({s8, c8, ov8, ac8} !== 18'b0) begin
        n_fail++;
        $display("FAIL reset_w8 cyc%0d got s=%h c=%h ov=%b ac=%b want all 0",
                 i, s8, c8, ov8, ac8);
      end
    end
    rst = 1'b0;
    v1  = 1'b0;
    v8  = 1'b0;
    tick();
    n_checks++;
    if ({s1, c1, ov1, ac1, s8, c8, ov8, ac8} !== 22'b0) begin
      n_fail++;
      $display("FAIL reset_release got w1=%b%b%b%b w8 s=%h c=%h ov=%b ac=%b want 0",
               s1, c1, ov1, ac1, s8, c8, ov8, ac8);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_cs [4];
    logic [1:0] in_ab;
    exp_cs = '{2'b00, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      in_ab = 2'(i);
      a1 = in_ab[1];
      b1 = in_ab[0];
      v1 = 1'b1;
      tick();
      n_checks++;
      if ({c1, s1} !== exp_cs[i] || ov1 !== 1'b1 ||
          ac1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL truth_ab%b got cs=%b%b ov=%b ac=%b want cs=%b ov=1 ac=%0d",
                 in_ab, c1, s1, ov1, ac1, exp_cs[i], (i == 3));
      end
    end
  endtask

  task automatic test_hold_xmask();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick();
    n_checks++;
    if ({c1, s1, ov1, ac1} !== 4'b1011) begin
      n_fail++;
      $display("FAIL hold_capture got c=%b s=%b ov=%b ac=%b want c=1 s=0 ov=1 ac=1",
               c1, s1, ov1, ac1);
    end
    for (int i = 0; i < 3; i++) begin
      a1 = 1'bx; b1 = 1'bx; v1 = 1'b0;
      tick();
      n_checks++;
      if ({c1, s1, ov1, ac1} !== 4'b1001) begin
        n_fail++;
        $display("FAIL hold_x cyc%0d got c=%b s=%b ov=%b ac=%b want c=1 s=0 ov=0 ac=1",
                 i, c1, s1, ov1, ac1);
      end
    end
    a1 = 1'b0; b1 = 1'b0;
  endtask

  task automatic test_lanes();
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    tick();
    n_checks++;
    if (s8 !== 8'h3C || c8 !== 8'hC0 || ac8 !== 1'b1 || ov8 !== 1'b1) begin
      n_fail++;
      $display("FAIL lanes_f0cc got s=%h c=%h ac=%b ov=%b want s=3c c=c0 ac=1 ov=1",
               s8, c8, ac8, ov8);
    end
    a8 = 8'h0F; b8 = 8'h30;
    tick();
    n_checks++;
    if (s8 !== 8'h3F || c8 !== 8'h00 || ac8 !== 1'b0 || ov8 !== 1'b1) begin
      n_fail++;
      $display("FAIL lanes_0f30 got s=%h c=%h ac=%b ov=%b want s=3f c=00 ac=0 ov=1",
               s8, c8, ac8, ov8);
    end
    v8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({c1, s1, ov1, ac1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_edge got c=%b s=%b ov=%b ac=%b want all 0",
               c1, s1, ov1, ac1);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({c1, s1, ov1, ac1} !== 4'b1011) begin
      n_fail++;
      $display("FAIL midrst_after got c=%b s=%b ov=%b ac=%b want c=1 s=0 ov=1 ac=1",
               c1, s1, ov1, ac1);
    end
    v1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] m_s, m_c;
    logic       m_ov, m_ac;
    m_s = '0; m_c = '0; m_ov = 1'b0; m_ac = 1'b0;
    for (int i = 0; i < 100; i++) begin
      v8 = (i == 0) ? 1'b1 : 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (!v8) begin
        a8 = 8'bx;
        b8 = 8'bx;
      end
      if (v8) begin
        for (int k = 0; k < 8; k++) begin
          m_s[k] = (a8[k] != b8[k]);
          m_c[k] = (a8[k] == 1'b1) && (b8[k] == 1'b1);
        end
        m_ac = (m_c != 8'h00);
      end
      m_ov = v8;
      tick();
      n_checks++;
      if (s8 !== m_s || c8 !== m_c || ov8 !== m_ov || ac8 !== m_ac) begin
        n_fail++;
        $display("FAIL b2b cyc%0d got s=%h c=%h ov=%b ac=%b want s=%h c=%h ov=%b ac=%b",
                 i, s8, c8, ov8, ac8, m_s, m_c, m_ov, m_ac);
      end
    end
    v8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = '0;   b8 = '0;   v8 = 1'b0;
    test_reset();
    test_truth_table();
    test_hold_xmask();
    test_lanes();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
